// File: rtl/div_unit.sv
// div_unit: 32-bit iterative divider, unsigned or two's-complement.
//
// One quotient bit per cycle using restoring radix-2 division on operand
// magnitudes, followed by a single sign-correction cycle. Divide-by-zero
// and the single signed-overflow case (most-negative / -1) skip the
// iterations and go straight to the correction/done sequence.
//
// Ports:
//   clk        rising-edge clock
//   reset_b    synchronous active-low reset
//   start      begin a division (only looked at while idle)
//   abort      cancel the operation in progress (also vetoes a start)
//   is_signed  1 = two's-complement, 0 = unsigned; captured with start
//   din_a      dividend; captured with start
//   din_b      divisor; captured with start
//   busy       high while an accepted operation is in progress
//   done       one-cycle pulse when results are updated
//   quotient   registered quotient (0xFFFFFFFF on divide-by-zero)
//   remainder  registered remainder (dividend on divide-by-zero)
//   dzout      divide-by-zero flag of the last completed operation
//   vout       signed-overflow flag of the last completed operation
//   qnzout     quotient is non-zero
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic              abort,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] din_a,
    input  logic [DATA_W-1:0] din_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              dzout,
    output logic              vout,
    output logic              qnzout
);
    localparam int                CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
        return -v;
    endfunction

    // Magnitude of an operand; the most negative value maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] f_mag(input logic signed [DATA_W-1:0] v,
                                                 input logic                     use_sign);
        return (use_sign && (v < 0)) ? f_neg(v) : v;
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_finish;
    logic [CNT_W-1:0]    r_cnt;

    // Working registers (data only, not reset)
    logic [DATA_W-1:0]   r_q;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_b;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_dz;
    logic                r_ov;

    // Registered outputs
    logic                r_done;
    logic [DATA_W-1:0]   r_quotient;
    logic [DATA_W-1:0]   r_remainder;
    logic                r_dzout;
    logic                r_vout;
    logic                r_qnzout;

    logic signed [DATA_W-1:0] w_a_s;
    logic signed [DATA_W-1:0] w_b_s;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_dz;
    logic                w_ov;
    logic                w_bypass;
    logic [DATA_W:0]     w_trial;
    logic [DATA_W:0]     w_diff;
    logic                w_ge;

    assign w_a_s    = din_a;
    assign w_b_s    = din_b;
    assign w_a_neg  = is_signed && (w_a_s < 0);
    assign w_b_neg  = is_signed && (w_b_s < 0);
    assign w_dz     = (din_b == '0);
    assign w_ov     = is_signed && (din_a == MOST_NEG) && (din_b == '1);
    assign w_bypass = w_dz || w_ov;

    // Shift the next dividend bit into the partial remainder and try the
    // subtract. The trial value is below 2*divisor, so bit DATA_W of the
    // 33-bit difference is set exactly when the subtract borrows.
    assign w_trial = {r_rem, r_q[DATA_W-1]};
    assign w_diff  = w_trial - {1'b0, r_b};
    assign w_ge    = ~w_diff[DATA_W];

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_accept = 1'b1;
                    w_next   = w_bypass ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_cnt == LAST_ITER) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_next   = S_IDLE;
                w_finish = !abort;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dzout     <= 1'b0;
            r_vout      <= 1'b0;
            r_qnzout    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish) begin
                r_quotient  <= r_q;
                r_remainder <= r_rem;
                r_dzout     <= r_dz;
                r_vout      <= r_ov;
                r_qnzout    <= (r_q != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Special cases preload their final result; the sign
                    // flags stay clear so the correction cycle passes it through.
                    r_q     <= w_dz ? '1 : (w_ov ? MOST_NEG : f_mag(w_a_s, is_signed));
                    r_rem   <= w_dz ? din_a : '0;
                    r_b     <= f_mag(w_b_s, is_signed);
                    r_neg_q <= !w_bypass && (w_a_neg ^ w_b_neg);
                    r_neg_r <= !w_bypass && w_a_neg;
                    r_dz    <= w_dz;
                    r_ov    <= w_ov;
                end
            end
            S_CALC: begin
                r_q   <= {r_q[DATA_W-2:0], w_ge};
                r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
            end
            S_FIX: begin
                if (r_neg_q) begin
                    r_q <= f_neg(r_q);
                end
                if (r_neg_r) begin
                    r_rem <= f_neg(r_rem);
                end
            end
            default: begin
            end
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign dzout     = r_dzout;
    assign vout      = r_vout;
    assign qnzout    = r_qnzout;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001: The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below (clock and reset first).
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset_b  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004: start  input  1  request to begin a division; sampled only in IDLE.
REQ-005: abort  input  1  cancels an operation in progress.
REQ-006: is_signed  input  1  selects two's-complement division when 1 and unsigned division when 0; captured with start.
REQ-007: din_a  input  32  dividend; captured with start.
REQ-008: din_b  input  32  divisor; captured with start.
REQ-009: busy  output  1  high while an accepted operation is in progress.
REQ-010: done  output  1  single-cycle pulse; results valid from that cycle onward.
REQ-011: quotient  output  32  registered quotient.
REQ-012: remainder  output  32  registered remainder.
REQ-013: dzout  output  1  divide-by-zero flag for the last completed operation.
REQ-014: vout  output  1  signed-overflow flag for the last completed operation.
REQ-015: qnzout  output  1  high when quotient is non-zero.

Function
REQ-016: The state machine SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-017: In IDLE, start=1 and abort=0 at edge k SHALL accept the operation: operands and is_signed captured, busy=1 from edge k.
REQ-018: In IDLE, start=1 and abort=1 in the same cycle SHALL accept nothing; abort wins.
REQ-019: start while busy=1 SHALL be ignored and SHALL have no effect on the operation in progress.
REQ-020: Operand changes after edge k SHALL NOT affect the result.
REQ-021: Normal path: IDLE -> CALC, then 32 restoring radix-2 iterations (edges k+1..k+32), one quotient bit per cycle, MSB first.
REQ-022: The CALC datapath SHALL use 32-bit magnitudes with a 33-bit partial-remainder subtract.
REQ-023: FIX (edge k+33) SHALL apply sign correction when is_signed=1:
  - quotient negated when the operand signs differ;
  - remainder carries the sign of the dividend;
  - quotient truncates toward zero.
REQ-024: DONE SHALL register the outputs at edge k+34; done=1 and busy=0 for exactly the cycle after edge k+34, then the FSM returns to IDLE.
REQ-025: A new start SHALL be accepted in the cycle in which done=1.
REQ-026: Divide by zero (din_b=0) SHALL bypass CALC: IDLE -> FIX -> DONE, with done at edge k+2 and the results:
  - quotient=0xFFFFFFFF;
  - remainder=din_a;
  - dzout=1;
  - vout=0.
REQ-027: Signed overflow (is_signed=1, din_a=0x80000000, din_b=0xFFFFFFFF) SHALL bypass CALC with done at edge k+2 and the results:
  - quotient=0x80000000;
  - remainder=0;
  - vout=1;
  - dzout=0.
REQ-028: All other completed operations SHALL produce dzout=0 and vout=0.
REQ-029: quotient, remainder, dzout, vout and qnzout SHALL update only at the DONE edge and SHALL hold until the next completed operation.
REQ-030: abort=1 while busy SHALL return the FSM to IDLE at the next edge, with busy=0, no done pulse and outputs unchanged.
REQ-031: The block SHALL contain no combinational path from any input to any output.

Reset
REQ-032: reset_b=0 at a rising edge SHALL force the FSM to IDLE and set busy=0, done=0, quotient=0, remainder=0, dzout=0, vout=0, qnzout=0.
REQ-033: Reset SHALL take priority over start, abort and any in-progress operation.
REQ-034: The first start SHALL be accepted on the first edge at which reset_b=1.

Verification
REQ-035: The bench SHALL cover unsigned 100/7, start at edge k -> quotient=14, remainder=2, qnzout=1, done only in the cycle after edge k+34, busy=1 for edges k..k+33.
REQ-036: The bench SHALL cover signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, vout=0, dzout=0.
REQ-037: The bench SHALL cover 5/0 (unsigned and signed) -> quotient=0xFFFFFFFF, remainder=5, dzout=1, done at edge k+2.
REQ-038: The bench SHALL cover signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, vout=1, done at edge k+2; the same operands unsigned -> quotient=0, remainder=0x80000000, qnzout=0.
REQ-039: The bench SHALL cover reset_b=0 at edge k+10 of a division -> next cycle busy=0, all outputs 0, no done pulse; abort at k+10 -> busy=0, previous results retained, no done pulse.
REQ-040: The bench SHALL cover a start pulse with different operands at k+5 during a division -> ignored, first result unchanged; a back-to-back start in the done cycle -> accepted, second done 35 cycles after the first.
